// File: rtl/misuratore_frequenza.sv
// rtl/misuratore_frequenza.sv - gated rising-edge counter (frequency/event meter) driving the LEDs
//
// Purpose: counts rising edges of an asynchronous input over a fixed window of
//   GATE_CYCLES clk cycles and publishes each window's count on led.
// Ports:
//   clk       in   1      system clock
//   rst       in   1      asynchronous reset, active-high
//   sig_in    in   1      external signal, asynchronous to clk
//   led       out  CNT_W  rising-edge count of the last completed window
//   valid     out  1      one-cycle pulse when led is updated
//   overflow  out  1      last completed window saturated the count
// Build option: define DEBOUNCE_EN to insert a DEBOUNCE_CYCLES stability filter
//   between the synchroniser and the edge detector.
module misuratore_frequenza #(
  parameter int GATE_CYCLES     = 100_000_000,
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 1_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] led,
  output logic             valid,
  output logic             overflow
);

  localparam int               GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level;
  logic                   prev_q;
  logic                   rise;
  logic                   term;
  logic                   at_max;
  logic [GW-1:0]          gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]       led_q, led_d;
  logic                   sat_q, sat_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;

  // Metastability synchroniser: sig_in enters at bit 0, oldest sample at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
  end

`ifdef DEBOUNCE_EN
  localparam int            DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          db_level_q, db_level_d;

  // The filtered level follows the synchronised input only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the run.
  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    if (sync_q[SYNC_STAGES-1] != db_level_q) begin
      if (db_cnt_q == DB_LAST) db_level_d = sync_q[SYNC_STAGES-1];
      else                     db_cnt_d   = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
    end
  end

  assign level = db_level_q;
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif

  assign rise   = level & ~prev_q;
  assign term   = (gate_cnt_q == GATE_LAST);
  assign at_max = (edge_cnt_q == CNT_MAX);

  always_comb begin
    gate_cnt_d = term ? '0 : gate_cnt_q + 1'b1;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    led_d      = led_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;

    // Saturating count; a rise lost at the ceiling is remembered as overflow.
    if (rise) begin
      if (at_max) sat_d      = 1'b1;
      else        edge_cnt_d = edge_cnt_q + 1'b1;
    end

    // Publish the already-updated count so a rise on the terminal cycle
    // belongs to the window that is closing, then start the next window empty.
    if (term) begin
      led_d      = edge_cnt_d;
      ovf_d      = sat_d;
      valid_d    = 1'b1;
      edge_cnt_d = '0;
      sat_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= 1'b0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      led_q      <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      prev_q     <= level;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      led_q      <= led_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign led      = led_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;

endmodule
